usb_in_ep_buffer: RTL and testbench

- Device-side responder for the USB IN-endpoint client interface (req/grant/free/put/done/acked) used by the serial endpoint glue.
- Grants one client, collects up to MAX_PKT bytes into a single packet buffer and presents the finished packet to the USB protocol engine.
- Tracks the DATA0/DATA1 toggle and retransmits until the host ACKs, then pulses acked back to the client.

---
 rtl/usb_in_ep_buffer_if.sv | 42 ++++
 rtl/usb_in_ep_buffer.sv | 142 ++++++++++++++
 tb/tb_usb_in_ep_buffer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_in_ep_buffer_if.sv
// Client-side and USB-engine-side signals of the IN-endpoint packet buffer.
// The buffer uses the slave modport; the client/engine pair uses master.
interface usb_in_ep_buffer_if #(
    parameter int MAX_PKT = 32,
    parameter int PTR_W   = $clog2(MAX_PKT) + 1
);
    logic             in_ep_req;
    logic             in_ep_grant;
    logic             in_ep_data_free;
    logic             in_ep_data_put;
    logic [7:0]       in_ep_data;
    logic             in_ep_data_done;
    logic             in_ep_stall;
    logic             in_ep_acked;
    logic             tx_pkt_ready;
    logic [PTR_W-1:0] tx_pkt_len;
    logic             tx_data_toggle;
    logic             tx_stall;
    logic             tx_start;
    logic             tx_data_get;
    logic [7:0]       tx_data;
    logic             tx_data_last;
    logic             tx_sent;
    logic             tx_ack;
    logic             tx_timeout;
    logic             toggle_clear;
    logic             overflow;

    modport slave (
        input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
        input  tx_start, tx_data_get, tx_sent, tx_ack, tx_timeout, toggle_clear,
        output in_ep_grant, in_ep_data_free, in_ep_acked, tx_pkt_ready, tx_pkt_len,
        output tx_data_toggle, tx_stall, tx_data, tx_data_last, overflow
    );

    modport master (
        output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
        output tx_start, tx_data_get, tx_sent, tx_ack, tx_timeout, toggle_clear,
        input  in_ep_grant, in_ep_data_free, in_ep_acked, tx_pkt_ready, tx_pkt_len,
        input  tx_data_toggle, tx_stall, tx_data, tx_data_last, overflow
    );
endinterface

// File: rtl/usb_in_ep_buffer.sv
// Single-packet USB IN-endpoint buffer: collects a client packet, hands it to
// the protocol engine, retransmits on timeout and tracks the DATA0/DATA1 toggle.
module usb_in_ep_buffer #(
    parameter int MAX_PKT = 32,
    parameter int PTR_W   = $clog2(MAX_PKT) + 1
) (
    input logic               clk,
    input logic               reset,
    usb_in_ep_buffer_if.slave ep
);
    localparam int               ADDR_W  = PTR_W - 1;
    localparam logic [PTR_W-1:0] MAX_CNT = PTR_W'(MAX_PKT);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READY,
        SEND,
        WAIT_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] len_q, len_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             toggle_q, toggle_d;
    logic             acked_q, acked_d;
    logic             overflow_q, overflow_d;
    logic             stall_q;
    logic [7:0]       mem [MAX_PKT];
    logic             put_ok;
    logic [PTR_W:0]   fill_sum;

    // One extra bit so count+put never wraps when compared against MAX_PKT.
    assign fill_sum = {1'b0, count_q} + {{PTR_W{1'b0}}, ep.in_ep_data_put};
    assign put_ok   = (state_q == FILL) && ep.in_ep_data_put && (count_q < MAX_CNT);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        tx_data_d  = tx_data_q;
        toggle_d   = toggle_q;
        acked_d    = 1'b0;
        overflow_d = overflow_q | (ep.in_ep_data_put && (count_q == MAX_CNT));

        case (state_q)
            IDLE: begin
                if (ep.in_ep_req) begin
                    state_d = FILL;
                    count_d = '0;
                end
            end
            FILL: begin
                if (put_ok) begin
                    count_d = count_q + 1'b1;
                end
                if (ep.in_ep_data_done || (put_ok && (count_q == MAX_CNT - 1'b1))) begin
                    state_d = READY;
                    len_d   = put_ok ? count_q + 1'b1 : count_q;
                end else if (!ep.in_ep_req && (count_q == '0) && !ep.in_ep_data_put) begin
                    state_d = IDLE;
                end
            end
            READY: begin
                if (ep.tx_start) begin
                    state_d  = SEND;
                    rd_ptr_d = '0;
                end
            end
            SEND: begin
                if (ep.tx_data_get && (rd_ptr_q != len_q)) begin
                    tx_data_d = mem[rd_ptr_q[ADDR_W-1:0]];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                end
                if (ep.tx_sent) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ep.tx_ack) begin
                    toggle_d = ~toggle_q;
                    acked_d  = 1'b1;
                    count_d  = '0;
                    state_d  = IDLE;
                end else if (ep.tx_timeout) begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase

        // A configuration-level clear overrides the toggle flip of a coincident ACK.
        if (ep.toggle_clear) begin
            toggle_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            tx_data_q  <= '0;
            toggle_q   <= 1'b0;
            acked_q    <= 1'b0;
            overflow_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            tx_data_q  <= tx_data_d;
            toggle_q   <= toggle_d;
            acked_q    <= acked_d;
            overflow_q <= overflow_d;
            stall_q    <= ep.in_ep_stall;
        end
    end

    always_ff @(posedge clk) begin
        if (put_ok) begin
            mem[count_q[ADDR_W-1:0]] <= ep.in_ep_data;
        end
    end

    assign ep.in_ep_grant     = (state_q == FILL);
    assign ep.in_ep_data_free = (state_q == FILL) && (fill_sum < {1'b0, MAX_CNT});
    assign ep.in_ep_acked     = acked_q;
    assign ep.tx_pkt_ready    = (state_q == READY);
    assign ep.tx_pkt_len      = len_q;
    assign ep.tx_data_toggle  = toggle_q;
    assign ep.tx_stall        = stall_q;
    assign ep.tx_data         = tx_data_q;
    // Qualified by SEND so the flag stays low at reset and while no packet is being read.
    assign ep.tx_data_last    = (state_q == SEND) && (rd_ptr_q == len_q);
    assign ep.overflow        = overflow_q;
endmodule

// File: tb/tb_usb_in_ep_buffer.sv
// Self-checking bench for usb_in_ep_buffer: directed corner cases plus random
// packets, compared against a byte-queue model of the endpoint.
module tb_usb_in_ep_buffer;
    localparam int MAX_PKT = 32;
    localparam int PTR_W   = $clog2(MAX_PKT) + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    usb_in_ep_buffer_if #(.MAX_PKT(MAX_PKT), .PTR_W(PTR_W)) ep ();

    usb_in_ep_buffer #(.MAX_PKT(MAX_PKT), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .ep    (ep)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] pkt_q[$];
    logic       model_toggle   = 1'b0;
    logic       model_overflow = 1'b0;
    logic [7:0] model_tx_data  = 8'h00;
    logic       stall_prev     = 1'b0;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        ep.in_ep_req       = 1'b0;
        ep.in_ep_data_put  = 1'b0;
        ep.in_ep_data      = 8'h00;
        ep.in_ep_data_done = 1'b0;
        ep.tx_start        = 1'b0;
        ep.tx_data_get     = 1'b0;
        ep.tx_sent         = 1'b0;
        ep.tx_ack          = 1'b0;
        ep.tx_timeout      = 1'b0;
        ep.toggle_clear    = 1'b0;
    endtask

    // One clock; tx_stall must echo the stall input of the previous cycle.
    task automatic tick();
        stall_prev = ep.in_ep_stall;
        @(posedge clk);
        #1;
        checkOutput("tx_stall", ep.tx_stall, stall_prev);
        ep.in_ep_stall = 1'($urandom_range(0, 1));
    endtask

    // Grant a fill and load n bytes; packet closes on done or when full.
    task automatic applyStimulus(input int n, input bit done_with_last, input bit gaps, input bit fixed);
        pkt_q.delete();
        ep.in_ep_req = 1'b1;
        #1;
        checkOutput("grant_before_edge", ep.in_ep_grant, 0);
        tick();
        checkOutput("grant_rise", ep.in_ep_grant, 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                ep.in_ep_data_put  = 1'b0;
                ep.in_ep_data_done = 1'b0;
                tick();
                checkOutput("grant_hold_gap", ep.in_ep_grant, 1);
            end
            ep.in_ep_req       = 1'b0;
            ep.in_ep_data      = fixed ? 8'(8'h41 + i) : 8'($urandom);
            ep.in_ep_data_put  = 1'b1;
            ep.in_ep_data_done = done_with_last && (i == n - 1);
            #1;
            checkOutput("free_on_put", ep.in_ep_data_free, (i + 1) < MAX_PKT);
            pkt_q.push_back(ep.in_ep_data);
            tick();
        end
        ep.in_ep_req       = 1'b0;
        ep.in_ep_data_put  = 1'b0;
        ep.in_ep_data_done = 1'b0;
        if (!(done_with_last && n > 0) && n < MAX_PKT) begin
            ep.in_ep_data_done = 1'b1;
            tick();
            ep.in_ep_data_done = 1'b0;
        end
        checkOutput("grant_drop", ep.in_ep_grant, 0);
        checkOutput("pkt_ready", ep.tx_pkt_ready, 1);
        checkOutput("pkt_len", ep.tx_pkt_len, pkt_q.size());
        checkOutput("toggle_ready", ep.tx_data_toggle, model_toggle);
        checkOutput("overflow_ready", ep.overflow, model_overflow);
    endtask

    // Engine side: start, pull every byte (plus a couple of surplus gets), then tx_sent.
    task automatic readPacket(input bit gaps);
        int idx   = 0;
        int extra = 0;
        int n     = pkt_q.size();
        ep.tx_start = 1'b1;
        tick();
        ep.tx_start = 1'b0;
        checkOutput("ready_low_in_send", ep.tx_pkt_ready, 0);
        checkOutput("last_at_start", ep.tx_data_last, n == 0);
        for (int cyc = 0; cyc < 200 && (idx < n || extra < 2); cyc++) begin
            logic get;
            get            = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ep.tx_data_get = get;
            tick();
            if (get) begin
                if (idx < n) begin
                    model_tx_data = pkt_q[idx];
                    idx++;
                end else begin
                    extra++;
                end
            end
            checkOutput("tx_data", ep.tx_data, model_tx_data);
            checkOutput("tx_data_last", ep.tx_data_last, idx == n);
        end
        ep.tx_data_get = 1'b0;
        checkOutput("bytes_pulled", idx, n);
        ep.tx_sent = 1'b1;
        tick();
        ep.tx_sent = 1'b0;
        checkOutput("ready_low_wait", ep.tx_pkt_ready, 0);
    endtask

    // Handshake phase: ack, timeout or both, optionally with toggle_clear.
    task automatic finishAck(input bit ack, input bit timeout, input bit clr);
        ep.tx_ack       = ack;
        ep.tx_timeout   = timeout;
        ep.toggle_clear = clr;
        tick();
        ep.tx_ack       = 1'b0;
        ep.tx_timeout   = 1'b0;
        ep.toggle_clear = 1'b0;
        if (ack) begin
            model_toggle = clr ? 1'b0 : ~model_toggle;
            checkOutput("acked_pulse", ep.in_ep_acked, 1);
            checkOutput("ready_after_ack", ep.tx_pkt_ready, 0);
        end else begin
            if (clr) model_toggle = 1'b0;
            checkOutput("no_acked_timeout", ep.in_ep_acked, 0);
            checkOutput("ready_retx", ep.tx_pkt_ready, timeout);
            checkOutput("len_retx", ep.tx_pkt_len, pkt_q.size());
        end
        checkOutput("toggle", ep.tx_data_toggle, model_toggle);
        tick();
        checkOutput("acked_one_cycle", ep.in_ep_acked, 0);
    endtask

    // Client that registers put from the previous cycle's free flag.
    task automatic fullPacketRegistered();
        int   mc        = 0;
        logic prev_free = 1'b0;
        pkt_q.delete();
        ep.in_ep_req = 1'b1;
        tick();
        for (int cyc = 0; cyc < 80; cyc++) begin
            ep.in_ep_data_put = prev_free;
            ep.in_ep_data     = 8'($urandom);
            #1;
            checkOutput("free_registered", ep.in_ep_data_free, (mc + prev_free) < MAX_PKT);
            if (prev_free && mc < MAX_PKT) begin
                pkt_q.push_back(ep.in_ep_data);
                mc++;
            end
            prev_free = ep.in_ep_data_free;
            tick();
            if (ep.tx_pkt_ready) break;
        end
        ep.in_ep_req      = 1'b0;
        ep.in_ep_data_put = 1'b0;
        checkOutput("full_auto_ready", ep.tx_pkt_ready, 1);
        checkOutput("full_count", mc, MAX_PKT);
        checkOutput("full_len", ep.tx_pkt_len, MAX_PKT);
        checkOutput("full_no_overflow", ep.overflow, 0);
        ep.in_ep_data_put = 1'b1;
        ep.in_ep_data     = 8'hEE;
        tick();
        ep.in_ep_data_put = 1'b0;
        model_overflow    = 1'b1;
        checkOutput("overflow_set", ep.overflow, 1);
        checkOutput("len_after_overflow", ep.tx_pkt_len, MAX_PKT);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        ep.in_ep_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_grant", ep.in_ep_grant, 0);
        checkOutput("rst_free", ep.in_ep_data_free, 0);
        checkOutput("rst_acked", ep.in_ep_acked, 0);
        checkOutput("rst_ready", ep.tx_pkt_ready, 0);
        checkOutput("rst_len", ep.tx_pkt_len, 0);
        checkOutput("rst_toggle", ep.tx_data_toggle, 0);
        checkOutput("rst_stall", ep.tx_stall, 0);
        checkOutput("rst_data", ep.tx_data, 0);
        checkOutput("rst_last", ep.tx_data_last, 0);
        checkOutput("rst_overflow", ep.overflow, 0);
        reset = 1'b0;

        // 5-byte packet 0x41..0x45, done with the last put.
        applyStimulus(5, 1'b1, 1'b0, 1'b1);
        readPacket(1'b0);
        finishAck(1'b1, 1'b0, 1'b0);

        fullPacketRegistered();
        readPacket(1'b0);
        finishAck(1'b1, 1'b0, 1'b0);

        // Retransmit after timeout, then a single toggle flip on ack.
        applyStimulus(4, 1'b1, 1'b0, 1'b0);
        readPacket(1'b0);
        finishAck(1'b0, 1'b1, 1'b0);
        readPacket(1'b1);
        finishAck(1'b1, 1'b0, 1'b0);

        // Zero-length packet.
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        readPacket(1'b0);
        finishAck(1'b1, 1'b0, 1'b0);

        // Ack beats timeout; then clear beats ack while toggle is 0.
        applyStimulus(3, 1'b1, 1'b0, 1'b0);
        readPacket(1'b0);
        finishAck(1'b1, 1'b1, 1'b0);
        applyStimulus(2, 1'b0, 1'b0, 1'b0);
        readPacket(1'b0);
        finishAck(1'b1, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 1'b0, 1'b0);
        readPacket(1'b0);
        finishAck(1'b1, 1'b0, 1'b1);

        // Request withdrawn before any byte.
        ep.in_ep_req = 1'b1;
        tick();
        checkOutput("grant_req_drop_pre", ep.in_ep_grant, 1);
        ep.in_ep_req = 1'b0;
        tick();
        checkOutput("grant_req_drop", ep.in_ep_grant, 0);
        tick();
        checkOutput("idle_after_drop", ep.tx_pkt_ready, 0);

        // Asynchronous reset after three bytes of a fill.
        ep.in_ep_req = 1'b1;
        tick();
        ep.in_ep_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ep.in_ep_data_put = 1'b1;
            ep.in_ep_data     = 8'($urandom);
            tick();
        end
        ep.in_ep_data_put = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("midrst_grant", ep.in_ep_grant, 0);
        checkOutput("midrst_ready", ep.tx_pkt_ready, 0);
        checkOutput("midrst_toggle", ep.tx_data_toggle, 0);
        checkOutput("midrst_overflow", ep.overflow, 0);
        checkOutput("midrst_acked", ep.in_ep_acked, 0);
        model_toggle   = 1'b0;
        model_overflow = 1'b0;
        model_tx_data  = 8'h00;
        ep.in_ep_stall = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(6, 1'b1, 1'b0, 1'b0);
        readPacket(1'b0);
        finishAck(1'b1, 1'b0, 1'b0);

        // Random packets with gaps, retransmits and toggle clears.
        for (int p = 0; p < 25; p++) begin
            int n;
            int retries;
            n       = $urandom_range(0, MAX_PKT);
            retries = $urandom_range(0, 2);
            applyStimulus(n, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            for (int r = 0; r < retries; r++) begin
                readPacket(1'b1);
                finishAck(1'b0, 1'b1, 1'($urandom_range(0, 3) == 0));
            end
            readPacket(1'b1);
            finishAck(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
